// File: rtl/prog_sequencer.sv
// Run controller: launches NUM_PROGS programs back to back on one core and records each one's cycle count.
// Optional watchdog abort per program when PROG_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps

module prog_sequencer #(
  parameter int NUM_PROGS   = 3,
  parameter int PC_W        = 16,
  parameter int CYC_W       = 16,
  parameter int START_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      go,
  input  logic [NUM_PROGS*PC_W-1:0] entry_table,
  input  logic                      core_halt,
  output logic                      core_start,
  output logic [PC_W-1:0]           core_entry,
  output logic [IDX_W-1:0]          prog_idx,
  output logic                      busy,
  output logic                      all_done,
  output logic [NUM_PROGS-1:0]      done_flags,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [CYC_W-1:0]          rd_cycles,
  output logic [NUM_PROGS-1:0]      timed_out
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  localparam int              LC_W        = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [LC_W-1:0] LAUNCH_LAST = LC_W'(START_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_MAX    = '1;
  // A limit the counter cannot represent collapses onto the saturation value.
  localparam logic [CYC_W-1:0] TIMEOUT_VAL =
    ((64'(TIMEOUT_CYC) >> CYC_W) != 64'd0) ? CYC_MAX : CYC_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PROGS - 1);

`ifdef PROG_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_t            state, state_next;
  logic [LC_W-1:0]   launch_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [CYC_W-1:0]  counts [NUM_PROGS];
  logic [IDX_W-1:0]  next_idx;
  logic              start_req, launch_end, timeout_hit, prog_end, last_prog;

  assign start_req   = go && ((state == S_IDLE) || (state == S_DONE));
  assign launch_end  = (state == S_LAUNCH) && (launch_cnt == LAUNCH_LAST);
  assign timeout_hit = WD_EN && (state == S_RUN) && !core_halt && (cyc_cnt == TIMEOUT_VAL);
  assign prog_end    = (state == S_RUN) && (core_halt || timeout_hit);
  assign last_prog   = (prog_idx == LAST_IDX);
  assign next_idx    = prog_idx + IDX_W'(1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    core_start = 1'b1;
    busy       = 1'b0;
    all_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy = 1'b1;
        if (launch_end) state_next = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_start = 1'b0;
        if (prog_end) state_next = last_prog ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        all_done = 1'b1;
        if (go) state_next = S_LAUNCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the count slots are a handful of flops that must read 0 straight out of reset, so they are reset like any other register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      launch_cnt <= '0;
      cyc_cnt    <= '0;
      prog_idx   <= '0;
      core_entry <= '0;
      done_flags <= '0;
      timed_out  <= '0;
      for (int i = 0; i < NUM_PROGS; i++) counts[i] <= '0;
    end else if (start_req) begin
      launch_cnt <= '0;
      prog_idx   <= '0;
      core_entry <= entry_table[PC_W-1:0];
      done_flags <= '0;
      timed_out  <= '0;
      for (int i = 0; i < NUM_PROGS; i++) counts[i] <= '0;
    end else if (state == S_LAUNCH) begin
      if (launch_end) cyc_cnt    <= '0;
      else            launch_cnt <= launch_cnt + LC_W'(1);
    end else if (state == S_RUN) begin
      if (prog_end) begin
        counts[prog_idx]     <= cyc_cnt;
        done_flags[prog_idx] <= 1'b1;
        if (timeout_hit) timed_out[prog_idx] <= 1'b1;
        if (!last_prog) begin
          prog_idx   <= next_idx;
          core_entry <= entry_table[int'(next_idx)*PC_W +: PC_W];
          launch_cnt <= '0;
        end
      end else if (cyc_cnt != CYC_MAX) begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
    end
  end

  always_comb begin
    rd_cycles = '0;
    if (int'(rd_idx) < NUM_PROGS) rd_cycles = counts[rd_idx];
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus pushes expected launches/counts, a monitor pops on DUT events.
`timescale 1ns/1ps

module tb_prog_sequencer;
  localparam int NP = 3, PC_W = 16, CYC_W = 16, START_CYC = 2, TMO = 50;

  logic                 clk = 1'b0, reset = 1'b1, go = 1'b0, core_halt = 1'b0;
  logic [NP*PC_W-1:0]   entry_table = {16'h0080, 16'h0040, 16'h0000};
  logic                 core_start, busy, all_done;
  logic [PC_W-1:0]      core_entry;
  logic [1:0]           prog_idx, rd_idx = 2'd0;
  logic [NP-1:0]        done_flags, timed_out;
  logic [CYC_W-1:0]     rd_cycles;

  // Narrow-counter, single-program instance for saturation.
  logic                 go_s = 1'b0, halt_s = 1'b0, core_start_s, busy_s, all_done_s;
  logic [0:0]           prog_idx_s, rd_idx_s = 1'b0, done_flags_s, timed_out_s;
  logic [15:0]          core_entry_s;
  logic [3:0]           rd_cycles_s;

  always #5 clk = ~clk;

  prog_sequencer #(.NUM_PROGS(NP), .PC_W(PC_W), .CYC_W(CYC_W), .START_CYC(START_CYC),
                   .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .reset(reset), .go(go), .entry_table(entry_table), .core_halt(core_halt),
    .core_start(core_start), .core_entry(core_entry), .prog_idx(prog_idx), .busy(busy),
    .all_done(all_done), .done_flags(done_flags), .rd_idx(rd_idx), .rd_cycles(rd_cycles),
    .timed_out(timed_out));

  prog_sequencer #(.NUM_PROGS(1), .PC_W(16), .CYC_W(4), .START_CYC(2), .TIMEOUT_CYC(4096)) dut_sat (
    .CLK(clk), .reset(reset), .go(go_s), .entry_table(16'h1234), .core_halt(halt_s),
    .core_start(core_start_s), .core_entry(core_entry_s), .prog_idx(prog_idx_s), .busy(busy_s),
    .all_done(all_done_s), .done_flags(done_flags_s), .rd_idx(rd_idx_s), .rd_cycles(rd_cycles_s),
    .timed_out(timed_out_s));

  typedef struct { logic [1:0] idx; logic [15:0] cnt; } cnt_exp_t;
  typedef struct { logic [2:0] flags; logic [2:0] tmo; } done_exp_t;
  cnt_exp_t  cnt_q[$];
  done_exp_t done_q[$];
  logic [15:0] entry_q[$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic push_cnt(input logic [1:0] idx, input logic [15:0] cnt);
    cnt_exp_t e;
    e.idx = idx;
    e.cnt = cnt;
    cnt_q.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] flags, input logic [2:0] tmo);
    done_exp_t e;
    e.flags = flags;
    e.tmo   = tmo;
    done_q.push_back(e);
  endtask

  // Monitor: checks launches, recorded counts and run completion as the DUT presents them.
  initial begin
    logic [2:0] prev_flags, new_bits, cur_flags;
    logic       prev_start, prev_done, cur_start, cur_done;
    int         hi;
    cnt_exp_t   ce;
    done_exp_t  de;
    logic [15:0] ee;
    prev_flags = '0; prev_start = 1'b1; prev_done = 1'b0; hi = 0;
    forever begin
      @(negedge clk);
      cur_flags = done_flags; cur_start = core_start; cur_done = all_done;
      if (busy && cur_start) hi++;
      if (prev_start && !cur_start) begin
        if (entry_q.size() == 0) fail("unexpected_launch");
        else begin
          ee = entry_q.pop_front();
          check("core_entry", 64'(core_entry), 64'(ee));
        end
        check("start_width", 64'(hi), 64'(START_CYC));
        hi = 0;
      end
      if (!busy) hi = 0;
      new_bits = cur_flags & ~prev_flags;
      if (new_bits != 3'b000) begin
        if (cnt_q.size() == 0) fail("unexpected_completion");
        else begin
          ce = cnt_q.pop_front();
          check("done_bit", 64'(new_bits), 64'(3'b001 << ce.idx));
          rd_idx = ce.idx;
          #1;
          check("rd_cycles", 64'(rd_cycles), 64'(ce.cnt));
        end
      end
      if (cur_done && !prev_done) begin
        if (done_q.size() == 0) fail("unexpected_all_done");
        else begin
          de = done_q.pop_front();
          check("done_flags_final", 64'(cur_flags), 64'(de.flags));
          check("timed_out_final", 64'(timed_out), 64'(de.tmo));
          rd_idx = 2'd3;
          #1;
          check("rd_out_of_range", 64'(rd_cycles), 64'd0);
        end
      end
      prev_flags = cur_flags; prev_start = cur_start; prev_done = cur_done;
    end
  end

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (!(busy && !core_start)) begin
      @(negedge clk);
      k++;
      if (k > 100) begin fail("wait_run_timeout"); return; end
    end
  endtask

  // Halt arrives after n RUN cycles; optionally pulse go mid-run.
  task automatic run_prog(input int n, input bit poke_go);
    wait_run();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      go = poke_go && (i == 4);
    end
    go = 1'b0;
    if (poke_go) begin
      check("go_ignored_idx", 64'(prog_idx), 64'd1);
      check("go_ignored_start", 64'(core_start), 64'd0);
    end
    core_halt = 1'b1;
    @(negedge clk) core_halt = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!all_done) begin
      @(negedge clk);
      k++;
      if (k > bound) begin fail("wait_done_timeout"); return; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic flush();
    cnt_q.delete();
    done_q.delete();
    entry_q.delete();
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_core_start", 64'(core_start), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_flags", 64'(done_flags), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_start", 64'(core_start), 64'd1);
    check("idle_prog_idx", 64'(prog_idx), 64'd0);
    check("idle_all_done", 64'(all_done), 64'd0);
    check("idle_timed_out", 64'(timed_out), 64'd0);
    check("idle_core_entry", 64'(core_entry), 64'd0);
    check("idle_rd_cycles", 64'(rd_cycles), 64'd0);

    // Normal run 10/25/7 with a go pulse mid prog 1
    entry_q.push_back(16'h0000); entry_q.push_back(16'h0040); entry_q.push_back(16'h0080);
    push_cnt(2'd0, 16'd10); push_cnt(2'd1, 16'd25); push_cnt(2'd2, 16'd7);
    push_done(3'b111, 3'b000);
    pulse_go();
    run_prog(10, 1'b0);
    run_prog(25, 1'b1);
    run_prog(7, 1'b0);
    wait_done(50);
    check("done_busy", 64'(busy), 64'd0);
    check("done_core_start", 64'(core_start), 64'd1);

    // Immediate halt, restarted from DONE
    core_halt = 1'b1;
    entry_q.push_back(16'h0000); entry_q.push_back(16'h0040); entry_q.push_back(16'h0080);
    push_cnt(2'd0, 16'd0); push_cnt(2'd1, 16'd0); push_cnt(2'd2, 16'd0);
    push_done(3'b111, 3'b000);
    pulse_go();
    check("restart_flags_clear", 64'(done_flags), 64'd0);
    check("restart_prog_idx", 64'(prog_idx), 64'd0);
    check("restart_entry", 64'(core_entry), 64'h0000);
    cyc = 0;
    while (!all_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("imm_halt_cycles", 64'(cyc), 64'd9);
    core_halt = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while prog 1 runs
    entry_q.push_back(16'h0000); entry_q.push_back(16'h0040);
    push_cnt(2'd0, 16'd5);
    pulse_go();
    run_prog(5, 1'b0);
    wait_run();
    repeat (3) @(negedge clk);
    check("pre_reset_idx", 64'(prog_idx), 64'd1);
    reset = 1'b1;
    #1;
    flush();
    check("mid_rst_core_start", 64'(core_start), 64'd1);
    check("mid_rst_prog_idx", 64'(prog_idx), 64'd0);
    check("mid_rst_done_flags", 64'(done_flags), 64'd0);
    check("mid_rst_all_done", 64'(all_done), 64'd0);
    check("mid_rst_rd_cycles", 64'(rd_cycles), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Saturation on a 4-bit counter
    @(negedge clk) go_s = 1'b1;
    @(negedge clk) go_s = 1'b0;
    cyc = 0;
    while (core_start_s && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    halt_s = 1'b1;
    @(negedge clk) halt_s = 1'b0;
    cyc = 0;
    while (!all_done_s && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_all_done", 64'(all_done_s), 64'd1);
    check("sat_count", 64'(rd_cycles_s), 64'd15);
    check("sat_entry", 64'(core_entry_s), 64'h1234);
    rd_idx_s = 1'b1;
    #1;
    check("sat_rd_oob", 64'(rd_cycles_s), 64'd0);

    // Program 1 never halts
    entry_q.push_back(16'h0000); entry_q.push_back(16'h0040);
    push_cnt(2'd0, 16'd3);
`ifdef PROG_SEQ_WATCHDOG_EN
    entry_q.push_back(16'h0080);
    push_cnt(2'd1, 16'(TMO)); push_cnt(2'd2, 16'd4);
    push_done(3'b111, 3'b010);
    pulse_go();
    run_prog(3, 1'b0);
    wait_run();
    cyc = 0;
    while (prog_idx != 2'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("wd_advance", 64'(prog_idx), 64'd2);
    run_prog(4, 1'b0);
    wait_done(50);
    check("wd_all_done", 64'(all_done), 64'd1);
`else
    pulse_go();
    run_prog(3, 1'b0);
    wait_run();
    repeat (300) @(negedge clk);
    check("nowd_busy", 64'(busy), 64'd1);
    check("nowd_prog_idx", 64'(prog_idx), 64'd1);
    check("nowd_done_flags", 64'(done_flags), 64'b001);
    check("nowd_timed_out", 64'(timed_out), 64'd0);
    reset = 1'b1;
    #1;
    flush();
    @(negedge clk) reset = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("queues_drained", 64'(cnt_q.size() + done_q.size() + entry_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    fail("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Harness-level run controller for the basic processor.
- Launches NUM_PROGS programs back to back on one core instance. For each program it drives core init/start and the entry PC, waits for the core's halt flag, and records the executed-cycle count per program.
- all_done rises only when every program has halted, which replaces hand-checking three separate done flags.
- Sits between the testbench and the core top level: it drives the core's start input and watches its halt output.

Parameters:
- NUM_PROGS, 3, number of programs run in sequence (1..16).
- PC_W, 16, width of entry PC and program counter.
- CYC_W, 16, width of each per-program cycle counter.
- START_CYC, 2, cycles core_start is held high per launch (>=1).
- TIMEOUT_CYC, 4096, watchdog limit in cycles; used only with PROG_SEQ_WATCHDOG_EN.

Ports:
- CLK, input, 1, clock; posedge only.
- reset, input, 1, asynchronous active-high reset.
- go, input, 1, one-cycle pulse that starts a full run from program 0.
- entry_table, input, NUM_PROGS*PC_W, entry PC for each program; program i occupies bits [i*PC_W +: PC_W].
- core_halt, input, 1, halt flag from the core.
- core_start, output, 1, init/reset to the core, active high.
- core_entry, output, PC_W, entry PC for the current program; held stable for the whole program.
- prog_idx, output, $clog2(NUM_PROGS) or 1, index of the current program.
- busy, output, 1, high in LAUNCH and RUN.
- all_done, output, 1, high in DONE.
- done_flags, output, NUM_PROGS, sticky per-program halted flags.
- rd_idx, input, $clog2(NUM_PROGS) or 1, cycle-count read select.
- rd_cycles, output, CYC_W, recorded count for rd_idx; combinational read.
- timed_out, output, NUM_PROGS, per-program watchdog flags; constant 0 without the macro.

Behaviour:
- Reset values (asynchronous): state=IDLE, core_start=1 so the core is held in init, core_entry=0, prog_idx=0, busy=0, all_done=0, done_flags=0, timed_out=0, all count registers=0.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - core_start=1.
  - go=1 → clear done_flags, timed_out and all counts; prog_idx=0; go to LAUNCH on the next edge.
- LAUNCH:
  - core_start=1 for exactly START_CYC cycles, counted by a launch counter.
  - core_entry = entry_table[prog_idx], registered on entry to LAUNCH.
  - core_halt is ignored here.
  - After START_CYC cycles → RUN. The cycle counter is cleared to 0 on that transition.
- RUN:
  - core_start=0.
  - Each cycle with core_halt=0 the counter increments by 1, saturating at 2^CYC_W-1 with no wrap.
  - First cycle with core_halt=1:
    - the count is written to slot prog_idx and done_flags[prog_idx] is set on the same edge;
    - if prog_idx==NUM_PROGS-1 → DONE, otherwise prog_idx+1 → LAUNCH.
  - A halt already high in the first RUN cycle records a count of 0.
- DONE:
  - all_done=1, core_start=1, busy=0.
  - go=1 → restarts the full run, same as from IDLE.
- go is ignored in LAUNCH and RUN; no restart mid-run.
- A go pulse on the same edge a program completes is ignored.
- reset asserted mid-run aborts immediately. All outputs return to their reset values and the recorded counts are lost.
- rd_idx >= NUM_PROGS → rd_cycles=0.
- The count equals the number of core clock edges with core_start=0 and halt=0, which matches the core's own cycle counter.

Optional Feature:
PROG_SEQ_WATCHDOG_EN
- Defined:
  - In RUN, when the counter reaches TIMEOUT_CYC with core_halt still 0, the sequencer records TIMEOUT_CYC as the count.
  - It sets timed_out[prog_idx] and done_flags[prog_idx], then advances exactly as if halt had occurred.
  - Halt and timeout on the same cycle → treated as halt; timed_out stays 0.
- Not defined: no timeout. RUN waits indefinitely and the counter saturates; timed_out is tied to 0.

Test Plan:
1. Reset mid-RUN, with NUM_PROGS=3, START_CYC=2 and entries 0x0000/0x0040/0x0080: assert reset while prog 1 is running → next cycle core_start=1, prog_idx=0, done_flags=000, all_done=0.
2. Normal run: halts arrive after 10, 25 and 7 RUN cycles → rd_cycles reads 10/25/7, done_flags=111, all_done=1. Check core_entry per launch and core_start high for exactly 2 cycles per launch.
3. Immediate halt: core_halt held 1 throughout LAUNCH and into RUN → counts 0/0/0, three launches, all_done after 3×(2+1) cycles.
4. Saturation: CYC_W=4, halt after 20 cycles → recorded count 15.
5. go ignored: pulse go during prog 1 RUN → no effect on prog_idx or counts. Then pulse go in DONE → flags clear and prog 0 relaunches with entry 0x0000.
6. Watchdog (PROG_SEQ_WATCHDOG_EN, TIMEOUT_CYC=50): prog 1 never halts → count 50, timed_out=010, sequencer advances to prog 2, all_done=1. Without the macro, the same stimulus keeps busy=1 indefinitely.
